uart_rx: RTL
============

# uart_rx

Oversampling UART receiver: the line-side counterpart of the UART transmitter, consuming the serial stream and delivering parallel words with parity and framing status. Sits between the shared UPDI line and the UPDI response-handling logic. Runs on a clock at OVERSAMPLE × baud and recovers bit centres from the start-bit falling edge. Frame format is parameter-matched to the transmitter (UPDI uses 8 data bits, even parity, 2 stop bits).

## Interface
- DATA_BITS, 8: data bits per frame, 5–9.
- PARITY_BIT, "none": "none", "even" or "odd".
- STOP_BITS, 1: stop bits checked, 1–2.
- OVERSAMPLE, 16: clk cycles per bit, even, ≥ 4.

- clk  input  1  oversampling clock (OVERSAMPLE × baud).
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- rx  input  1  serial line, asynchronous to clk, idle high.
- rx_data  output  DATA_BITS  last received word, LSB first on the line.
- valid  output  1  one-cycle pulse when rx_data and the flags update.
- parity_err  output  1  parity mismatch on the last frame (always 0 when PARITY_BIT is "none").
- frame_err  output  1  a stop-bit sample read 0 on the last frame.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.
- States come from uart_state: IDLE, START, DATA, PARITY, STOP.
- os_cnt is $clog2(OVERSAMPLE) bits wide. bit_cnt is wide enough for max(DATA_BITS, STOP_BITS).
- IDLE: when `armed` and rxs == 0, go to START and clear os_cnt. `armed` sets on any cycle with rxs == 1.
- START: sample at os_cnt == OVERSAMPLE/2−1.
  - Sample 1: false start. Return to IDLE with no output change.
  - Sample 0: clear os_cnt and bit_cnt, go to DATA.
- DATA, PARITY, STOP: os_cnt counts 0..OVERSAMPLE−1, and each state samples at os_cnt == OVERSAMPLE−1, which is the bit centre.
- DATA: shift the sample into the MSB of the shift register (right shift). After DATA_BITS samples, go to PARITY, or to STOP if PARITY_BIT is "none".
- PARITY: the expected bit is XOR(data) for "even" and ~XOR(data) for "odd". Latch the mismatch.
- STOP: take STOP_BITS samples and OR any zero into the frame error.
- On the final stop sample (same edge):
  - rx_data ← shift register, and parity_err/frame_err ← latched values.
  - valid ← 1 for exactly one cycle. State ← IDLE.
  - If a frame error occurred, clear `armed`, so a held-low line (break) is reported once and no new start is detected until rxs returns to 1.
- rx_data, parity_err and frame_err hold until the next valid.
- Reset (any time, including mid-frame): state IDLE, valid 0, busy 0, rx_data 0, parity_err 0, frame_err 0, counters 0, `armed` 1. The partial frame is discarded.

## Timing
- Start detect is 2 cycles after the rx falling edge (synchronizer latency). The start-bit sample is OVERSAMPLE/2 cycles after the IDLE→START edge.
- Successive samples are spaced exactly OVERSAMPLE cycles apart.
- valid rises on the edge that takes the last stop sample, about (1 + DATA_BITS + P + STOP_BITS − 0.5) × OVERSAMPLE + 2 cycles after the rx falling edge, where P = 1 if parity is enabled, else 0.
- The receiver re-enters IDLE at mid-stop-bit, so back-to-back frames with no idle gap are accepted.
- There is no ready/backpressure: the consumer must accept on the valid cycle.

## Configuration
- UART_RX_MAJORITY_EN defined: a 3-entry history of rxs is kept. Every sample, including the start-bit check, uses the majority of rxs at cycles n−2, n−1 and n of the sample edge. This rejects single-cycle glitches.
- UART_RX_MAJORITY_EN undefined: each sample is rxs at the sample edge alone.
- Timing, latency and ports are identical in both builds.

## Structure
- The uart_state enum stays in the shared UART package; the receiver imports it and adds no new states.
- Reuse the existing parity module (BITS = DATA_BITS, odd-parity output) as the one sub-module for the expected-parity calculation.
- The synchronizer and majority logic are inline; no extra module.

## Test plan
All scenarios use DATA_BITS=8, PARITY_BIT="even", STOP_BITS=2, OVERSAMPLE=16.
- Frame 0x55, correct parity, 2 stop bits → one valid pulse, rx_data=0x55, parity_err=0, frame_err=0, busy falls on the same edge.
- Frame 0xA3 with the parity bit inverted → valid, rx_data=0xA3, parity_err=1, frame_err=0.
- rx low for 4 clk in idle (below half a bit) → START aborts, no valid, busy returns to 0. A following 0x3C frame is received correctly.
- Break: rx low for 30 bit times → exactly one valid with rx_data=0x00 and frame_err=1, and no further valid while low. After rx goes high, frame 0x3C gives valid with frame_err=0.
- rst driven low during data bit 4 → busy=0 and valid=0 immediately, all outputs 0. After release, frame 0x81 is received correctly.
- Frame 0xFF with rx forced low for 1 clk at the centre of bit 3 → with UART_RX_MAJORITY_EN: rx_data=0xFF; without: rx_data=0xF7. A parity error is expected in the second case.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART state encoding and elaboration helpers
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_parity.sv
// rtl/uart_rx_parity.sv - reduction parity; odd is high when data holds an odd number of ones
module uart_rx_parity #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] data,
    output logic            odd
);

    assign odd = ^data;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver recovering bit centres from the start edge
// Optional UART_RX_MAJORITY_EN: each sample is the 2-of-3 vote over the last three rxs values.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int    DATA_BITS  = 8,
    parameter string PARITY_BIT = "none",
    parameter int    STOP_BITS  = 1,
    parameter int    OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int CNT_W = $clog2(max2(DATA_BITS, STOP_BITS) + 1);

    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam bit               PAR_EN    = (PARITY_BIT != "none");
    localparam bit               PAR_ODD   = (PARITY_BIT == "odd");

    uart_state            state;
    logic                 sync1;
    logic                 rxs;
    logic                 samp;
    logic                 armed;
    logic [OS_W-1:0]      os_cnt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_lat;
    logic                 frm_lat;
    logic                 data_odd;
    logic                 exp_par;
    logic                 stop_fe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rxs};
        end
    end

    assign samp = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
    assign samp = rxs;
`endif

    uart_rx_parity #(
        .BITS (DATA_BITS)
    ) u_parity (
        .data (shreg),
        .odd  (data_odd)
    );

    assign exp_par = PAR_ODD ? ~data_odd : data_odd;
    assign stop_fe = frm_lat | ~samp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            valid      <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_lat    <= 1'b0;
            frm_lat    <= 1'b0;
            armed      <= 1'b1;
        end else begin
            valid <= 1'b0;
            if (rxs) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (armed && !rxs) begin
                        state  <= START;
                        busy   <= 1'b1;
                        os_cnt <= '0;
                    end
                end
                START: begin
                    if (os_cnt == OS_HALF) begin
                        if (samp) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            os_cnt  <= '0;
                            bit_cnt <= '0;
                            par_lat <= 1'b0;
                            frm_lat <= 1'b0;
                        end
                    end else begin
                        os_cnt <= os_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt <= '0;
                        shreg  <= {samp, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= PAR_EN ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        os_cnt <= os_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt  <= '0;
                        par_lat <= (samp != exp_par);
                        state   <= STOP;
                    end else begin
                        os_cnt <= os_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            rx_data    <= shreg;
                            parity_err <= par_lat;
                            frame_err  <= stop_fe;
                            valid      <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            bit_cnt    <= '0;
                            // Break: stay disarmed until the line returns high
                            if (stop_fe) begin
                                armed <= 1'b0;
                            end
                        end else begin
                            frm_lat <= stop_fe;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        os_cnt <= os_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
